// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART core: TX/RX FSMs with per-frame config latching and error flags.
// Build option UART_RX_FIFO_EN selects an RX_FIFO_DEPTH FWFT receive FIFO instead of a 1-entry register.
module uart_core_param #(
    parameter int DATA_BITS     = 8,
    parameter int DIV_W         = 16,
    parameter int RX_FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_W-1:0]     cfg_div,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_overrun,
    output logic                 tx,
    input  logic                 rx
);
    localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic [DIV_W-1:0] MIN_DIV  = DIV_W'(4);
    localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [DIV_W-1:0] div_eff;
    assign div_eff = (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;

    state_t                 tx_state_q;
    logic [DIV_W-1:0]       tx_cnt_q, tx_div_q;
    logic [3:0]             tx_idx_q;
    logic [DATA_BITS-1:0]   tx_shift_q;
    logic                   tx_par_en_q, tx_parbit_q, tx_stop2_q;
    logic                   tx_q, tx_busy_q, tx_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q  <= S_IDLE;
            tx_cnt_q    <= '0;
            tx_div_q    <= MIN_DIV;
            tx_idx_q    <= '0;
            tx_shift_q  <= '0;
            tx_par_en_q <= 1'b0;
            tx_parbit_q <= 1'b0;
            tx_stop2_q  <= 1'b0;
            tx_q        <= 1'b1;
            tx_busy_q   <= 1'b0;
            tx_ready_q  <= 1'b1;
        end else begin
            if (tx_state_q != S_IDLE) tx_cnt_q <= tx_cnt_q - ONE;
            case (tx_state_q)
                S_IDLE: if (tx_valid && tx_ready_q) begin
                    tx_state_q  <= S_START;
                    tx_q        <= 1'b0;
                    tx_busy_q   <= 1'b1;
                    tx_ready_q  <= 1'b0;
                    tx_shift_q  <= tx_data;
                    tx_div_q    <= div_eff;
                    tx_cnt_q    <= div_eff - ONE;
                    tx_par_en_q <= ^cfg_parity;
                    // cfg_parity[1] is set only for odd parity among the enabled modes
                    tx_parbit_q <= (^tx_data) ^ cfg_parity[1];
                    tx_stop2_q  <= cfg_stop2;
                end
                S_START: if (tx_cnt_q == '0) begin
                    tx_state_q <= S_DATA;
                    tx_q       <= tx_shift_q[0];
                    tx_shift_q <= tx_shift_q >> 1;
                    tx_idx_q   <= '0;
                    tx_cnt_q   <= tx_div_q - ONE;
                end
                S_DATA: if (tx_cnt_q == '0) begin
                    tx_cnt_q <= tx_div_q - ONE;
                    if (tx_idx_q == LAST_BIT) begin
                        tx_idx_q <= '0;
                        if (tx_par_en_q) begin
                            tx_state_q <= S_PARITY;
                            tx_q       <= tx_parbit_q;
                        end else begin
                            tx_state_q <= S_STOP;
                            tx_q       <= 1'b1;
                        end
                    end else begin
                        tx_idx_q   <= tx_idx_q + 4'd1;
                        tx_q       <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                    end
                end
                S_PARITY: if (tx_cnt_q == '0) begin
                    tx_state_q <= S_STOP;
                    tx_q       <= 1'b1;
                    tx_cnt_q   <= tx_div_q - ONE;
                end
                S_STOP: if (tx_cnt_q == '0) begin
                    if (tx_stop2_q && tx_idx_q == '0) begin
                        tx_idx_q <= 4'd1;
                        tx_cnt_q <= tx_div_q - ONE;
                    end else begin
                        tx_state_q <= S_IDLE;
                        tx_busy_q  <= 1'b0;
                        tx_ready_q <= 1'b1;
                    end
                end
                default: tx_state_q <= S_IDLE;
            endcase
        end
    end

    assign tx       = tx_q;
    assign tx_busy  = tx_busy_q;
    assign tx_ready = tx_ready_q;

    state_t                 rx_state_q;
    logic                   rx_s1_q, rx_s2_q, rx_prev_q;
    logic [DIV_W-1:0]       rx_cnt_q, rx_div_q;
    logic [3:0]             rx_idx_q;
    logic [DATA_BITS-1:0]   rx_shift_q;
    logic                   rx_par_en_q, rx_odd_q, rx_perr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= S_IDLE;
            rx_cnt_q    <= '0;
            rx_div_q    <= MIN_DIV;
            rx_idx_q    <= '0;
            rx_shift_q  <= '0;
            rx_par_en_q <= 1'b0;
            rx_odd_q    <= 1'b0;
            rx_perr_q   <= 1'b0;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            if (rx_state_q != S_IDLE) rx_cnt_q <= rx_cnt_q - ONE;
            case (rx_state_q)
                S_IDLE: if (rx_prev_q && !rx_s2_q) begin
                    rx_state_q  <= S_START;
                    rx_div_q    <= div_eff;
                    rx_cnt_q    <= (div_eff >> 1) - ONE;
                    rx_par_en_q <= ^cfg_parity;
                    rx_odd_q    <= cfg_parity[1];
                    rx_perr_q   <= 1'b0;
                end
                S_START: if (rx_cnt_q == '0) begin
                    // start bit gone high again by mid-bit: treat as a glitch
                    rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
                    rx_idx_q   <= '0;
                    rx_cnt_q   <= rx_div_q - ONE;
                end
                S_DATA: if (rx_cnt_q == '0) begin
                    rx_shift_q <= {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_cnt_q   <= rx_div_q - ONE;
                    rx_idx_q   <= rx_idx_q + 4'd1;
                    if (rx_idx_q == LAST_BIT) rx_state_q <= rx_par_en_q ? S_PARITY : S_STOP;
                end
                S_PARITY: if (rx_cnt_q == '0) begin
                    rx_perr_q  <= rx_s2_q ^ (^rx_shift_q) ^ rx_odd_q;
                    rx_state_q <= S_STOP;
                    rx_cnt_q   <= rx_div_q - ONE;
                end
                S_STOP: if (rx_cnt_q == '0) rx_state_q <= S_IDLE;
                default: rx_state_q <= S_IDLE;
            endcase
        end
    end

    logic                 rx_push;
    logic [DATA_BITS+1:0] rx_word;
    assign rx_push = (rx_state_q == S_STOP) && (rx_cnt_q == '0);
    assign rx_word = {rx_shift_q, rx_perr_q, !rx_s2_q};

`ifdef UART_RX_FIFO_EN
    localparam int PTR_W = $clog2(RX_FIFO_DEPTH);

    logic [DATA_BITS+1:0] fifo_mem_q [RX_FIFO_DEPTH];
    logic [PTR_W:0]       wr_ptr_q, rd_ptr_q;
    logic                 fifo_empty, fifo_full, fifo_pop, fifo_wr;
    logic                 rx_overrun_q;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign fifo_pop   = !fifo_empty && rx_ready;
    assign fifo_wr    = rx_push && (!fifo_full || fifo_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rx_overrun_q <= 1'b0;
        end else begin
            rx_overrun_q <= rx_push && !fifo_wr;
            if (fifo_wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
            if (fifo_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= rx_word;
    end

    // outputs forced to zero while empty so reset/idle values are defined
    assign rx_valid = !fifo_empty;
    assign {rx_data, rx_parity_err, rx_frame_err} =
        fifo_empty ? '0 : fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
    assign rx_overrun = rx_overrun_q;
`else
    logic [DATA_BITS+1:0] rx_hold_q;
    logic                 rx_valid_q, rx_overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_hold_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            rx_overrun_q <= 1'b0;
            if (rx_push) begin
                if (!rx_valid_q || rx_ready) begin
                    rx_hold_q  <= rx_word;
                    rx_valid_q <= 1'b1;
                end else begin
                    rx_overrun_q <= 1'b1;
                end
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx_valid = rx_valid_q;
    assign {rx_data, rx_parity_err, rx_frame_err} = rx_hold_q;
    assign rx_overrun = rx_overrun_q;
`endif

endmodule

// File: tb/tb_uart_core_param.sv
// Directed + randomized bench for uart_core_param; serial frames are predicted from data/parity/stop rules.
module tb_uart_core_param;
    localparam int DB = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] cfg_div = 16'd16;
    logic [1:0]    cfg_parity = 2'b00;
    logic          cfg_stop2 = 1'b0;
    logic [DB-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready, tx_busy, tx;
    logic [DB-1:0] rx_data;
    logic          rx_parity_err, rx_frame_err, rx_valid, rx_overrun;
    logic          rx_ready = 1'b1;
    logic          rx;
    logic          rx_drv = 1'b1;
    logic          loop = 1'b0;

    int errors = 0;
    int checks = 0;
    int ovr_cnt = 0;
    logic [DB+1:0] got [$];

    uart_core_param #(.DATA_BITS(DB), .DIV_W(DW), .RX_FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_div(cfg_div), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_overrun(rx_overrun), .tx(tx), .rx(rx)
    );

    always #5 clk = ~clk;
    assign rx = loop ? tx : rx_drv;

    always @(negedge clk) begin
        if (rst_n && rx_valid && rx_ready) got.push_back({rx_data, rx_parity_err, rx_frame_err});
        if (rx_overrun) ovr_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Line levels of one frame, start bit first.
    task automatic make_frame(input logic [7:0] d, input logic [1:0] par, input logic stop2,
                              output logic [15:0] bits, output int n);
        int ones;
        bits = '1;
        bits[0] = 1'b0;
        n = 1;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            bits[n] = d[i];
            ones += int'(d[i]);
            n++;
        end
        if (par == 2'b01) begin bits[n] = (ones % 2 == 1); n++; end
        else if (par == 2'b10) begin bits[n] = (ones % 2 == 0); n++; end
        bits[n] = 1'b1; n++;
        if (stop2) begin bits[n] = 1'b1; n++; end
    endtask

    task automatic send_tx(input logic [7:0] d, input int div, input logic [1:0] par,
                           input logic stop2, input bit scramble);
        logic [15:0] bits;
        int n, eff, busy_cnt, waitc;
        eff = (div < 4) ? 4 : div;
        make_frame(d, par, stop2, bits, n);
        @(negedge clk);
        cfg_div = DW'(div); cfg_parity = par; cfg_stop2 = stop2;
        tx_data = d; tx_valid = 1'b1;
        waitc = 0;
        while (!tx_ready && waitc < 2000) begin @(negedge clk); waitc++; end
        if (!tx_ready) begin
            chk("tx_accept_timeout", 32'(tx_ready), 32'd1);
            tx_valid = 1'b0;
            return;
        end
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data = 8'($urandom);
        busy_cnt = 0;
        for (int k = 0; k < n * eff; k++) begin
            chk($sformatf("tx_bit%0d_cyc%0d", k / eff, k), 32'(tx), 32'(bits[k / eff]));
            if (tx_busy && !tx_ready) busy_cnt++;
            if (scramble && k == 4) begin
                cfg_div = DW'($urandom_range(4, 30));
                cfg_parity = 2'($urandom);
                cfg_stop2 = 1'($urandom);
            end
            @(negedge clk);
        end
        chk("tx_busy_cycles", 32'(busy_cnt), 32'(n * eff));
        chk("tx_idle_after_frame", {29'd0, tx_busy, tx_ready, tx}, 32'b011);
    endtask

    task automatic drive_frame(input logic [7:0] d, input int div, input logic [1:0] par,
                               input logic flip_par, input logic stop_lvl);
        logic [15:0] bits;
        int n;
        make_frame(d, par, 1'b0, bits, n);
        if (flip_par) bits[9] = ~bits[9];
        bits[n - 1] = stop_lvl;
        cfg_div = DW'(div); cfg_parity = par;
        for (int k = 0; k < n; k++) begin
            rx_drv = bits[k];
            repeat (div) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    task automatic expect_rx(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        logic [DB+1:0] w;
        int waitc;
        waitc = 0;
        while (got.size() == 0 && waitc < 3000) begin @(negedge clk); waitc++; end
        if (got.size() == 0) begin
            chk({tag, "_timeout"}, 32'(got.size()), 32'd1);
            return;
        end
        w = got.pop_front();
        chk({tag, "_data"}, 32'(w[DB+1:2]), 32'(d));
        chk({tag, "_perr"}, 32'(w[1]), 32'(pe));
        chk({tag, "_ferr"}, 32'(w[0]), 32'(fe));
    endtask

    initial begin
        logic [7:0] d;
        int base;

        // reset state
        repeat (3) @(negedge clk);
        chk("reset_tx_lines", {29'd0, tx, tx_ready, tx_busy}, 32'b110);
        chk("reset_rx_flags", {28'd0, rx_valid, rx_parity_err, rx_frame_err, rx_overrun}, 32'd0);
        chk("reset_rx_data", 32'(rx_data), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 8'hA5 at div 4, no parity, one stop bit
        send_tx(8'hA5, 4, 2'b00, 1'b0, 1'b0);

        // loopback even parity, two stop bits
        loop = 1'b1;
        send_tx(8'h3C, 16, 2'b01, 1'b1, 1'b0);
        expect_rx("loop_3c", 8'h3C, 1'b0, 1'b0);
        send_tx(8'h00, 16, 2'b01, 1'b1, 1'b0);
        expect_rx("loop_00", 8'h00, 1'b0, 1'b0);

        // randomized loopback, config disturbed mid-frame
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            send_tx(d, $urandom_range(3, 20), 2'($urandom), 1'($urandom), 1'b1);
            expect_rx($sformatf("rand%0d", i), d, 1'b0, 1'b0);
        end
        loop = 1'b0;
        repeat (4) @(negedge clk);

        // odd parity: wrong then correct parity bit
        drive_frame(8'h01, 16, 2'b10, 1'b1, 1'b1);
        expect_rx("odd_bad", 8'h01, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        d = 8'($urandom);
        drive_frame(d, 16, 2'b10, 1'b0, 1'b1);
        expect_rx("odd_good", d, 1'b0, 1'b0);
        repeat (4) @(negedge clk);

        // stop bit driven low, then a short glitch
        drive_frame(8'h55, 16, 2'b00, 1'b0, 1'b0);
        expect_rx("break_55", 8'h55, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_no_word", 32'(got.size()), 32'd0);
        chk("glitch_no_valid", 32'(rx_valid), 32'd0);

        // consumer stalled
        rx_ready = 1'b0;
        base = ovr_cnt;
`ifdef UART_RX_FIFO_EN
        for (int i = 1; i <= 9; i++) begin
            drive_frame(8'(i), 16, 2'b00, 1'b0, 1'b1);
            repeat (4) @(negedge clk);
        end
        chk("fifo_overrun_count", 32'(ovr_cnt - base), 32'd1);
        chk("fifo_valid_held", 32'(rx_valid), 32'd1);
        rx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) expect_rx($sformatf("fifo%0d", i), 8'(i), 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("fifo_drained", 32'(rx_valid), 32'd0);
`else
        drive_frame(8'h11, 16, 2'b00, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        drive_frame(8'h22, 16, 2'b00, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("hold_valid", 32'(rx_valid), 32'd1);
        chk("hold_data", 32'(rx_data), 32'h11);
        chk("overrun_count", 32'(ovr_cnt - base), 32'd1);
        rx_ready = 1'b1;
        expect_rx("held_11", 8'h11, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("dropped_22", 32'(got.size()), 32'd0);
        chk("valid_cleared", 32'(rx_valid), 32'd0);
`endif

        // reset in the middle of a loopback frame
        loop = 1'b1;
        @(negedge clk);
        cfg_div = 16'd16; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        tx_data = 8'h5A; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (16 * 3 + 5) @(negedge clk);
        chk("midframe_busy", 32'(tx_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_tx_high", 32'(tx), 32'd1);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_tx_ready", {30'd0, tx_ready, tx_busy}, 32'b10);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        got.delete();
        repeat (3) @(negedge clk);
        send_tx(8'hC3, 16, 2'b00, 1'b0, 1'b0);
        expect_rx("after_reset_c3", 8'hC3, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        chk("no_spurious_rx", 32'(got.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
